// File: rtl/bit_serializer_pkg.sv
// Shared encodings for the serial sequence-detector path: FSM state values and
// the default word length used by the serializer and the detector.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serializer_if.sv
// Word-load handshake between a producer and the bit serializer.
interface bit_serializer_if #(
    parameter int WIDTH = bit_serializer_pkg::DEFAULT_WIDTH
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out front end: takes a WIDTH-bit word over valid/ready and
// streams it one bit per clock, reloading on the last bit so words run gapless.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    bit_serializer_if.slave  load,
    output logic             x_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic             ready;
    logic             accept;
    logic             last_bit;

    // NOTE: every signal gets a default at the top so no path through the
    // block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;

        last_bit = (state == SHIFT) && (bit_cnt == LAST);
        ready    = (state == IDLE) || last_bit;
        accept   = load.load_valid && ready;

        if (accept) begin
            shreg_nxt   = load.data_in;
            bit_cnt_nxt = '0;
            state_nxt   = SHIFT;
        end else if (last_bit) begin
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
        end else if (state == SHIFT) begin
            // Shift toward the output end so the next bit is always at the tap.
            shreg_nxt   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg[WIDTH-1:1]};
            bit_cnt_nxt = bit_cnt + 1'b1;
        end

        load.load_ready = ready;
        bit_valid       = (state == SHIFT);
        busy            = (state == SHIFT);
        frame_start     = (state == SHIFT) && (bit_cnt == '0);
        x_out           = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0])
                                           : 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first and one LSB-first instance,
// outputs sampled 1 time unit after each rising edge.
module tb_bit_serializer;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic a_x, a_bv, a_fs, a_busy;
    logic b_x, b_bv, b_fs, b_busy;

    bit_serializer_if #(.WIDTH(8)) la ();
    bit_serializer_if #(.WIDTH(8)) lb ();

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .load        (la.slave),
        .x_out       (a_x),
        .bit_valid   (a_bv),
        .frame_start (a_fs),
        .busy        (a_busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .load        (lb.slave),
        .x_out       (b_x),
        .bit_valid   (b_bv),
        .frame_start (b_fs),
        .busy        (b_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Packed order: {x_out, frame_start, bit_valid, busy, load_ready}
    task automatic sample_a(input string tag, input logic x, input logic fs,
                            input logic bv, input logic rdy);
        check(tag, {3'b0, a_x, a_fs, a_bv, a_busy, la.load_ready},
                   {3'b0, x, fs, bv, bv, rdy});
    endtask

    task automatic sample_b(input string tag, input logic x, input logic fs,
                            input logic bv, input logic rdy);
        check(tag, {3'b0, b_x, b_fs, b_bv, b_busy, lb.load_ready},
                   {3'b0, x, fs, bv, bv, rdy});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  word;
        logic [15:0] stream;

        reset = 1'b1;
        la.load_valid = 1'b0;
        la.data_in    = 8'h00;
        lb.load_valid = 1'b0;
        lb.data_in    = 8'h00;
        step();
        step();
        reset = 1'b0;
        sample_a("reset_a", 1'b0, 1'b0, 1'b0, 1'b1);
        sample_b("reset_b", 1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            step();
            sample_a($sformatf("idle_%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Single word 8'b1010_0000, MSB first
        word = 8'hA0;
        la.data_in    = word;
        la.load_valid = 1'b1;
        step();
        la.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample_a($sformatf("single_bit%0d", i), word[7-i], i == 0, 1'b1, i == 7);
            step();
        end
        sample_a("single_end", 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back A5 then 3C with load_valid held
        stream = 16'hA53C;
        la.data_in    = 8'hA5;
        la.load_valid = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            if (i == 0) la.data_in = 8'h3C;
            if (i == 8) la.load_valid = 1'b0;
            sample_a($sformatf("b2b_bit%0d", i), stream[15-i], (i == 0) || (i == 8),
                     1'b1, (i == 7) || (i == 15));
            step();
        end
        sample_a("b2b_end", 1'b0, 1'b0, 1'b0, 1'b1);

        // Stall: FF offered mid-frame of 00 must wait for the last bit
        la.data_in    = 8'h00;
        la.load_valid = 1'b1;
        step();
        la.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                la.data_in    = 8'hFF;
                la.load_valid = 1'b1;
            end
            sample_a($sformatf("stall_bit%0d", i), 1'b0, i == 0, 1'b1, i == 7);
            step();
        end
        la.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_a($sformatf("ff_bit%0d", i), 1'b1, i == 0, 1'b1, 1'b0);
            if (i < 3) step();
        end

        // Reset during bit 3 of FF
        reset = 1'b1;
        step();
        reset = 1'b0;
        sample_a("midreset", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            sample_a($sformatf("post_reset_%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Reset wins over an accept at the same edge
        reset = 1'b1;
        la.data_in    = 8'hFF;
        la.load_valid = 1'b1;
        step();
        reset = 1'b0;
        la.load_valid = 1'b0;
        sample_a("reset_vs_accept", 1'b0, 1'b0, 1'b0, 1'b1);

        // LSB-first instance: 8'h01 then 8'hA0
        word = 8'h01;
        lb.data_in    = word;
        lb.load_valid = 1'b1;
        step();
        lb.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample_b($sformatf("lsb01_bit%0d", i), word[i], i == 0, 1'b1, i == 7);
            step();
        end
        sample_b("lsb01_end", 1'b0, 1'b0, 1'b0, 1'b1);

        word = 8'hA0;
        lb.data_in    = word;
        lb.load_valid = 1'b1;
        step();
        lb.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample_b($sformatf("lsbA0_bit%0d", i), word[i], i == 0, 1'b1, i == 7);
            step();
        end
        sample_b("lsbA0_end", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
